// File: rtl/dcd_pkg.sv
// rtl/dcd_pkg.sv - state encoding and mode constants shared by the dcd_scan_nx slice
package dcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dcd_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dcd_prescaler.sv
// rtl/dcd_prescaler.sv - scan-rate prescaler, one-cycle tick every SCAN_DIV running cycles
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the count (wins over run)
//   run        : count enable
//   tick       : high while running with the count at SCAN_DIV-1
module dcd_prescaler #(
    parameter int SCAN_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = run && (count == CW'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/dcd_scan_nx.sv
// rtl/dcd_scan_nx.sv - registered N-to-2^N one-hot decoder with select handshake and auto-scan
//   Optional feature macro: DCD_SKIP_MASK_EN (adds skip_mask, masked indices are skipped in SCAN)
//   en, mode      : block enable, 0 = DIRECT / 1 = SCAN
//   sel, sel_vld  : DIRECT-mode select index and its valid; sel_rdy = en && !mode
//   dout          : registered one-hot (or all-zero) strobe vector
//   dout_vld      : dout holds a valid one-hot value
//   cur_idx       : index of the active output
module dcd_scan_nx
    import dcd_pkg::*;
#(
    parameter int N        = 2,
    parameter int OUTS     = 2**N,
    parameter int SCAN_DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    sel,
    input  logic            sel_vld,
`ifdef DCD_SKIP_MASK_EN
    input  logic [OUTS-1:0] skip_mask,
`endif
    output logic            sel_rdy,
    output logic [OUTS-1:0] dout,
    output logic            dout_vld,
    output logic [N-1:0]    cur_idx
);

    dcd_state_t      state, state_n;
    logic [OUTS-1:0] dout_n;
    logic            vld_n;
    logic [N-1:0]    idx_n;
    logic            pre_clr;
    logic            pre_run;
    logic            tick;
    logic [OUTS-1:0] mask;
    logic [N:0]      entry_hit;
    logic [N:0]      step_hit;

`ifdef DCD_SKIP_MASK_EN
    assign mask = skip_mask;
`else
    assign mask = '0;
`endif

    // Returns {found, index}: the first unmasked index at or after base, searching
    // with wrap. Descending loop so the smallest offset from base is the one kept.
    function automatic logic [N:0] find_unmasked(input logic [N-1:0]    base,
                                                 input logic [OUTS-1:0] msk);
        logic [N:0]   res;
        logic [N-1:0] idx;
        res = '0;
        for (int i = OUTS - 1; i >= 0; i--) begin
            idx = base + N'(i);
            if (!msk[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign entry_hit = find_unmasked('0, mask);
    assign step_hit  = find_unmasked(cur_idx + N'(1), mask);

    assign sel_rdy = en && (mode == MODE_DIRECT);
    assign pre_run = en && (mode == MODE_SCAN) && (state == SCAN);

    dcd_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .run   (pre_run),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        dout_n  = dout;
        vld_n   = dout_vld;
        idx_n   = cur_idx;
        pre_clr = 1'b0;
        if (!en) begin
            state_n = IDLE;
            dout_n  = '0;
            vld_n   = 1'b0;
            idx_n   = '0;
            pre_clr = 1'b1;
        end else if (mode == MODE_SCAN) begin
            state_n = SCAN;
            if (state != SCAN) begin
                // Scan (re)start from IDLE or DIRECT.
                pre_clr = 1'b1;
                if (entry_hit[N]) begin
                    idx_n  = entry_hit[N-1:0];
                    dout_n = OUTS'(1) << entry_hit[N-1:0];
                    vld_n  = 1'b1;
                end else begin
                    dout_n = '0;
                    vld_n  = 1'b0;
                end
            end else if (tick) begin
                // A fully masked vector blanks the strobe but keeps cur_idx, so
                // the next step searches on from where the scan left off.
                if (step_hit[N]) begin
                    idx_n  = step_hit[N-1:0];
                    dout_n = OUTS'(1) << step_hit[N-1:0];
                    vld_n  = 1'b1;
                end else begin
                    dout_n = '0;
                    vld_n  = 1'b0;
                end
            end
        end else begin
            // DIRECT: prescaler idles at zero; sel_rdy is already high here.
            state_n = DIRECT;
            pre_clr = 1'b1;
            if (sel_vld) begin
                idx_n  = sel;
                dout_n = OUTS'(1) << sel;
                vld_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dout     <= '0;
            dout_vld <= 1'b0;
            cur_idx  <= '0;
        end else begin
            state    <= state_n;
            dout     <= dout_n;
            dout_vld <= vld_n;
            cur_idx  <= idx_n;
        end
    end

endmodule
